ar_id_remapper: RTL and testbench

AR_ID_REMAPPER -- requirements
Module: ar_id_remapper

---
 rtl/ar_id_remapper.sv | 142 ++++++++++++++
 tb/tb_ar_id_remapper.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ar_id_remapper.sv
// ar_id_remapper: AR-channel ID remapper.
// Requests are held in a one-entry input stage until the ID allocator grants
// a unique ID. The request then moves into a one-entry output stage, which
// drives the downstream AR channel with the granted ID.
// Optional feature: define AR_REMAP_STALL_CNT_EN to add a 16-bit saturating
// count of cycles in which a held request could not be allocated.
module ar_id_remapper #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // upstream AR channel
  input  logic                  s_ar_valid,
  output logic                  s_ar_ready,
  input  logic [ID_WIDTH-1:0]   s_ar_id,
  input  logic [ADDR_WIDTH-1:0] s_ar_addr,
  input  logic [LEN_WIDTH-1:0]  s_ar_len,
  // ID allocator
  output logic                  alloc_req,
  output logic [ID_WIDTH-1:0]   alloc_orig_id,
  input  logic                  alloc_gnt,
  input  logic [ID_WIDTH-1:0]   alloc_unique_id,
  input  logic                  alloc_full,
  // downstream AR channel
  output logic                  m_ar_valid,
  input  logic                  m_ar_ready,
  output logic [ID_WIDTH-1:0]   m_ar_id,
  output logic [ADDR_WIDTH-1:0] m_ar_addr,
  output logic [LEN_WIDTH-1:0]  m_ar_len
`ifdef AR_REMAP_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  logic                  in_valid_q, in_valid_d;
  logic [ID_WIDTH-1:0]   in_id_q, in_id_d;
  logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
  logic [LEN_WIDTH-1:0]  in_len_q, in_len_d;

  logic                  out_valid_q, out_valid_d;
  logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [LEN_WIDTH-1:0]  out_len_q, out_len_d;

  logic fire;

  // Handshake decode. Requesting is only allowed when the output stage can
  // take the result this cycle; everything is masked while rst is high so a
  // reset cycle neither leaks an allocation nor accepts a request.
  always_comb begin
    alloc_req  = ~rst & in_valid_q & (~out_valid_q | m_ar_ready) & ~alloc_full;
    fire       = alloc_req & alloc_gnt;
    s_ar_ready = ~rst & (~in_valid_q | fire);
  end

  // Next-state for both stages: a new request replaces a departing one in
  // the same cycle, and a fire refills the output stage even while it drains.
  always_comb begin
    in_valid_d  = in_valid_q;
    in_id_d     = in_id_q;
    in_addr_d   = in_addr_q;
    in_len_d    = in_len_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_addr_d  = out_addr_q;
    out_len_d   = out_len_q;

    if (s_ar_valid && s_ar_ready) begin
      in_valid_d = 1'b1;
      in_id_d    = s_ar_id;
      in_addr_d  = s_ar_addr;
      in_len_d   = s_ar_len;
    end else if (fire) begin
      in_valid_d = 1'b0;
    end

    if (fire) begin
      out_valid_d = 1'b1;
      out_id_d    = alloc_unique_id;
      out_addr_d  = in_addr_q;
      out_len_d   = in_len_q;
    end else if (out_valid_q && m_ar_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Stage registers; reset discards any in-flight request and zeroes payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q  <= 1'b0;
      in_id_q     <= '0;
      in_addr_q   <= '0;
      in_len_q    <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_addr_q  <= '0;
      out_len_q   <= '0;
    end else begin
      in_valid_q  <= in_valid_d;
      in_id_q     <= in_id_d;
      in_addr_q   <= in_addr_d;
      in_len_q    <= in_len_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_addr_q  <= out_addr_d;
      out_len_q   <= out_len_d;
    end
  end

  assign alloc_orig_id = in_id_q;
  assign m_ar_valid    = out_valid_q;
  assign m_ar_id       = out_id_q;
  assign m_ar_addr     = out_addr_q;
  assign m_ar_len      = out_len_q;

`ifdef AR_REMAP_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a held request did not move on; saturate at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid_q && !fire && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ar_id_remapper.sv
// tb_ar_id_remapper: table-driven per-cycle checks of the handshake outputs
// plus a scoreboard following each request from upstream acceptance through
// allocation to the downstream channel.
module tb_ar_id_remapper;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int LW = 8;

  logic          clk;
  logic          rst;
  logic          s_ar_valid;
  logic          s_ar_ready;
  logic [IW-1:0] s_ar_id;
  logic [AW-1:0] s_ar_addr;
  logic [LW-1:0] s_ar_len;
  logic          alloc_req;
  logic [IW-1:0] alloc_orig_id;
  logic          alloc_gnt;
  logic [IW-1:0] alloc_unique_id;
  logic          alloc_full;
  logic          m_ar_valid;
  logic          m_ar_ready;
  logic [IW-1:0] m_ar_id;
  logic [AW-1:0] m_ar_addr;
  logic [LW-1:0] m_ar_len;
`ifdef AR_REMAP_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  ar_id_remapper #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
    .alloc_req(alloc_req), .alloc_orig_id(alloc_orig_id), .alloc_gnt(alloc_gnt),
    .alloc_unique_id(alloc_unique_id), .alloc_full(alloc_full),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len)
`ifdef AR_REMAP_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } req_t;

  req_t in_q[$];   // accepted upstream, awaiting allocation (original id)
  req_t out_q[$];  // allocated, awaiting downstream (unique id)
  logic hold_valid = 1'b0;
  req_t held;
  req_t cur;

  // Sample mid-cycle: downstream first, then allocation, then upstream, so
  // each event refers to the entry that was already present.
  always @(negedge clk) begin
    if (rst) begin
      in_q.delete();
      out_q.delete();
      hold_valid = 1'b0;
    end else begin
      if (hold_valid && m_ar_valid)
        check("m_ar_stable", {m_ar_id, m_ar_addr, m_ar_len}, held);
      hold_valid = m_ar_valid && !m_ar_ready;
      held = '{id: m_ar_id, addr: m_ar_addr, len: m_ar_len};

      if (m_ar_valid && m_ar_ready) begin
        if (out_q.size() == 0) begin
          check("m_ar_unexpected", m_ar_valid, 1'b0);
        end else begin
          cur = out_q.pop_front();
          check("m_ar_payload", {m_ar_id, m_ar_addr, m_ar_len}, cur);
          $display("out id=%0h addr=%0h len=%0d", m_ar_id, m_ar_addr, m_ar_len);
        end
      end

      if (alloc_req && in_q.size() == 0)
        check("alloc_req_empty", alloc_req, 1'b0);
      if (alloc_req && alloc_gnt && in_q.size() != 0) begin
        cur = in_q.pop_front();
        check("alloc_orig_id", alloc_orig_id, cur.id);
        out_q.push_back('{id: alloc_unique_id, addr: cur.addr, len: cur.len});
      end

      if (s_ar_valid && s_ar_ready)
        in_q.push_back('{id: s_ar_id, addr: s_ar_addr, len: s_ar_len});
    end
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic          sv;
    logic [IW-1:0] sid;
    logic [AW-1:0] saddr;
    logic [LW-1:0] slen;
    logic          gnt;
    logic [IW-1:0] uid;
    logic          full;
    logic          mrdy;
    logic          e_srdy;
    logic          e_areq;
    logic          e_mval;
    int            e_stall;  // -1: not checked
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic sv, input logic [IW-1:0] sid, input logic [AW-1:0] saddr,
                     input logic [LW-1:0] slen, input logic gnt, input logic [IW-1:0] uid,
                     input logic full, input logic mrdy, input logic e_srdy,
                     input logic e_areq, input logic e_mval, input int e_stall);
    vec_t v;
    v = '{sv, sid, saddr, slen, gnt, uid, full, mrdy, e_srdy, e_areq, e_mval, e_stall};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic sv, input logic [IW-1:0] sid, input logic [AW-1:0] saddr,
                       input logic [LW-1:0] slen, input logic gnt, input logic [IW-1:0] uid,
                       input logic full, input logic mrdy);
    s_ar_valid = sv; s_ar_id = sid; s_ar_addr = saddr; s_ar_len = slen;
    alloc_gnt = gnt; alloc_unique_id = uid; alloc_full = full; m_ar_ready = mrdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // single request: out two cycles after acceptance with unique id 4
    row(1, 4'h3, 32'h1000, 8'd7, 1, 4'h4, 0, 1,  1, 0, 0, 0);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h4, 0, 1,  1, 1, 0, -1);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h0, 0, 1,  1, 0, 1, -1);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h0, 0, 1,  1, 0, 0, -1);
    // back-to-back ids 1,1,2,3
    row(1, 4'h1, 32'h2000, 8'd0, 1, 4'h0, 0, 1,  1, 0, 0, -1);
    row(1, 4'h1, 32'h2040, 8'd1, 1, 4'h9, 0, 1,  1, 1, 0, -1);
    row(1, 4'h2, 32'h2080, 8'd2, 1, 4'hA, 0, 1,  1, 1, 1, -1);
    row(1, 4'h3, 32'h20C0, 8'd3, 1, 4'hB, 0, 1,  1, 1, 1, -1);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'hC, 0, 1,  1, 1, 1, -1);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h0, 0, 1,  1, 0, 1, -1);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h0, 0, 1,  1, 0, 0, -1);
    // allocator full for 5 cycles, second request offered but refused
    row(1, 4'h5, 32'h3000, 8'd2, 1, 4'h0, 0, 1,  1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      row(1, 4'h6, 32'h3100, 8'd3, 1, 4'h1, 1, 1,  0, 0, 0, -1);
    row(1, 4'h6, 32'h3100, 8'd3, 1, 4'h7, 0, 1,  1, 1, 0, -1);
    // downstream stall for 3 cycles, then drain-and-fire in the same cycle
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h8, 0, 0,  0, 0, 1, 5);
    row(0, 4'h0, 32'h0,    8'd0, 0, 4'h8, 0, 0,  0, 0, 1, -1);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h8, 0, 0,  0, 0, 1, -1);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h8, 0, 1,  1, 1, 1, -1);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h0, 0, 1,  1, 0, 1, -1);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h0, 0, 1,  1, 0, 0, -1);
    // no grant: request asserted but held
    row(1, 4'h2, 32'h4000, 8'd1, 0, 4'h0, 0, 1,  1, 0, 0, -1);
    row(0, 4'h0, 32'h0,    8'd0, 0, 4'h0, 0, 1,  0, 1, 0, -1);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h3, 0, 1,  1, 1, 0, -1);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h0, 0, 1,  1, 0, 1, -1);
    row(0, 4'h0, 32'h0,    8'd0, 1, 4'h0, 0, 1,  1, 0, 0, 9);

    // reset state
    rst = 1'b1;
    drive(0, 4'h0, 32'h0, 8'd0, 0, 4'h0, 0, 0);
    step();
    step();
    rst = 1'b0;
    #3;
    check("rst_s_ar_ready", s_ar_ready, 1'b1);
    check("rst_alloc_req", alloc_req, 1'b0);
    check("rst_alloc_orig_id", alloc_orig_id, '0);
    check("rst_m_ar_valid", m_ar_valid, 1'b0);
    check("rst_m_ar_payload", {m_ar_id, m_ar_addr, m_ar_len}, '0);
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sv, vecs[i].sid, vecs[i].saddr, vecs[i].slen,
            vecs[i].gnt, vecs[i].uid, vecs[i].full, vecs[i].mrdy);
      #3;
      $display("vec %0d: s_ar_ready=%0b alloc_req=%0b m_ar_valid=%0b",
               i, s_ar_ready, alloc_req, m_ar_valid);
      check($sformatf("vec%0d_s_ar_ready", i), s_ar_ready, vecs[i].e_srdy);
      check($sformatf("vec%0d_alloc_req", i), alloc_req, vecs[i].e_areq);
      check($sformatf("vec%0d_m_ar_valid", i), m_ar_valid, vecs[i].e_mval);
`ifdef AR_REMAP_STALL_CNT_EN
      if (vecs[i].e_stall >= 0)
        check($sformatf("vec%0d_stall_cnt", i), stall_cnt, vecs[i].e_stall);
`endif
      step();
    end

    // reset with both stages occupied
    drive(1, 4'hA, 32'h5000, 8'd4, 1, 4'hD, 0, 0);
    step();
    drive(1, 4'hB, 32'h5100, 8'd5, 1, 4'hE, 0, 0);
    step();
    drive(0, 4'h0, 32'h0, 8'd0, 1, 4'hF, 0, 0);
    #3;
    check("full_m_ar_valid", m_ar_valid, 1'b1);
    check("full_s_ar_ready", s_ar_ready, 1'b0);
    check("full_alloc_req", alloc_req, 1'b0);
    step();
    rst = 1'b1;
    drive(1, 4'hC, 32'h5200, 8'd6, 1, 4'h1, 0, 1);
    step();
    rst = 1'b0;
    drive(0, 4'h0, 32'h0, 8'd0, 1, 4'h0, 0, 1);
    #3;
    check("mid_rst_m_ar_valid", m_ar_valid, 1'b0);
    check("mid_rst_s_ar_ready", s_ar_ready, 1'b1);
    check("mid_rst_alloc_req", alloc_req, 1'b0);
    check("mid_rst_m_ar_payload", {m_ar_id, m_ar_addr, m_ar_len}, '0);
`ifdef AR_REMAP_STALL_CNT_EN
    check("mid_rst_stall_cnt", stall_cnt, 16'd0);
`endif
    step();
    for (int i = 0; i < 4; i++) begin
      #3;
      check($sformatf("post_rst%0d_m_ar_valid", i), m_ar_valid, 1'b0);
      step();
    end

    check("in_q_drained", in_q.size(), 0);
    check("out_q_drained", out_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
